// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control unit: FSM states, access-size
// encodings and the default MMIO window.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // mem_u_b_h_w encoding: bit0 = half, bit1 = word, bit2 = unsigned
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] DEF_MMIO_BASE = 32'hF000_0000;
  localparam logic [31:0] DEF_MMIO_MASK = 32'hF000_0000;

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational request classifier: RAM window, MMIO window and alignment.
module lsu_addr_decode
  import lsu_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 7,
  parameter logic [31:0] MMIO_BASE      = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK      = DEF_MMIO_MASK
) (
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  output logic        o_is_ram,
  output logic        o_is_mmio,
  output logic        o_misaligned
);

  assign o_misaligned = (i_size[0] & i_addr[0]) | (i_size[1] & (|i_addr[1:0]));
  assign o_is_mmio    = (i_addr & MMIO_MASK) == MMIO_BASE;
  assign o_is_ram     = ~(|i_addr[31:RAM_ADDR_WIDTH]);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request at a time, routed to the single-cycle RAM
// port or the ack-based MMIO port. Optional MMIO timeout: define LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 7,
  parameter logic [31:0] MMIO_BASE      = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK      = DEF_MMIO_MASK,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_dout,
  output logic        io_valid,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        io_we,
  output logic [2:0]  io_size,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_err;
  logic [2:0]  r_size;
  logic        w_is_ram, w_is_mmio, w_misaligned;
  logic        w_ram_we, w_io_valid, w_resp_valid, w_tmo;

  lsu_addr_decode #(
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
    .MMIO_BASE      (MMIO_BASE),
    .MMIO_MASK      (MMIO_MASK)
  ) u_decode (
    .i_addr       (req_addr),
    .i_size       (req_size),
    .o_is_ram     (w_is_ram),
    .o_is_mmio    (w_is_mmio),
    .o_misaligned (w_misaligned)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_tmo = 1'b0;
`endif

  // NOTE: asynchronous reset -- rst sits in the sensitivity list so state clears
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_ram_we     = 1'b0;
    w_io_valid   = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_misaligned)   w_state_nxt = ST_RESP;
          else if (w_is_mmio) w_state_nxt = ST_IO_WAIT;
          else if (w_is_ram)  w_state_nxt = ST_RAM_ACC;
          else                w_state_nxt = ST_RESP;
        end
      end
      ST_RAM_ACC: begin
        w_ram_we    = r_we;
        w_state_nxt = ST_RESP;
      end
      ST_IO_WAIT: begin
        // at the timeout limit the request is withdrawn, but a coincident ack still completes it
        w_io_valid = ~w_tmo;
        if (io_ack || w_tmo) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_we    <= req_we;
          r_size  <= req_size;
          r_rdata <= '0;
          r_err   <= w_misaligned | (~w_is_mmio & ~w_is_ram);
`ifdef LSU_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        ST_RAM_ACC: if (!r_we) r_rdata <= ram_dout;
        ST_IO_WAIT: begin
          if (io_ack) begin
            if (!r_we) r_rdata <= io_rdata;
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          else r_cnt <= r_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // strobes are also gated by rst so they fall the instant reset rises
  assign req_ready   = (r_state == ST_IDLE) & ~rst;
  assign ram_we      = w_ram_we & ~rst;
  assign io_valid    = w_io_valid & ~rst;
  assign resp_valid  = w_resp_valid;
  assign resp_rdata  = w_resp_valid ? r_rdata : 32'd0;
  assign resp_err    = w_resp_valid & r_err;

  assign ram_addr    = r_addr;
  assign ram_din     = r_wdata;
  assign ram_u_b_h_w = r_size;
  assign io_addr     = r_addr;
  assign io_wdata    = r_wdata;
  assign io_we       = r_we;
  assign io_size     = r_size;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a little-endian byte RAM model that places
// lanes and extends loads, writing on the falling edge.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;
  logic [2:0]  ram_u_b_h_w;
  logic        io_valid, io_we;
  logic [31:0] io_addr, io_wdata;
  logic [2:0]  io_size;
  logic        io_ack = 1'b0;
  logic [31:0] io_rdata = '0;

  int total = 0;
  int bad   = 0;
  int n_ram_we = 0, n_io_valid = 0, n_resp = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_u_b_h_w(ram_u_b_h_w), .ram_dout(ram_dout),
    .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
    .io_size(io_size), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [0:127];
  logic [6:0] a0, a1, a2, a3;
  assign a0 = ram_addr[6:0];
  assign a1 = 7'(a0 + 7'd1);
  assign a2 = 7'(a0 + 7'd2);
  assign a3 = 7'(a0 + 7'd3);

  always_comb begin
    case (ram_u_b_h_w)
      SZ_B:    ram_dout = {{24{mem[a0][7]}}, mem[a0]};
      SZ_BU:   ram_dout = {24'd0, mem[a0]};
      SZ_H:    ram_dout = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      SZ_HU:   ram_dout = {16'd0, mem[a1], mem[a0]};
      default: ram_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(negedge clk) begin
    if (ram_we) begin
      mem[a0] = ram_din[7:0];
      if (ram_u_b_h_w[0] | ram_u_b_h_w[1]) mem[a1] = ram_din[15:8];
      if (ram_u_b_h_w[1]) begin
        mem[a2] = ram_din[23:16];
        mem[a3] = ram_din[31:24];
      end
    end
    if (ram_we)     n_ram_we++;
    if (io_valid)   n_io_valid++;
    if (resp_valid) n_resp++;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [2:0] sz);
    @(negedge clk);
    req_addr = a; req_wdata = d; req_we = we; req_size = sz; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // lat counts negedges after the accept edge; -1 when no response arrives
  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%0b exp=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%0b exp=0", resp_valid); end
    total++; if (ram_we !== 1'b0)     begin bad++; $display("FAIL rst_ram_we got=%0b exp=0", ram_we); end
    total++; if (io_valid !== 1'b0)   begin bad++; $display("FAIL rst_io_valid got=%0b exp=0", io_valid); end
    total++; if (ram_addr !== 32'd0 || io_addr !== 32'd0 || resp_rdata !== 32'd0)
      begin bad++; $display("FAIL rst_data ram_addr=%h io_addr=%h rdata=%h exp=0", ram_addr, io_addr, resp_rdata); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL rst_release_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_ram_word();
    int lat; logic [31:0] rd; logic er; int we0;
    we0 = n_ram_we;
    issue(32'h10, 32'hDEAD_BEEF, 1'b1, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (n_ram_we - we0 != 1) begin bad++; $display("FAIL st_we_cycles got=%0d exp=1", n_ram_we - we0); end
    total++; if (lat != 2 || er !== 1'b0 || rd !== 32'd0)
      begin bad++; $display("FAIL st_resp lat=%0d err=%0b rdata=%h exp lat=2 err=0 rdata=0", lat, er, rd); end
    issue(32'h10, 32'h0, 1'b0, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (lat != 2) begin bad++; $display("FAIL ld_lat got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0)
      begin bad++; $display("FAIL ld_word got=%h err=%0b exp=deadbeef err=0", rd, er); end
  endtask

  task automatic test_ram_sizes();
    logic [31:0] addr [3] = '{32'h13, 32'h13, 32'h12};
    logic [2:0]  sz   [3] = '{SZ_B, SZ_BU, SZ_HU};
    logic [31:0] exp  [3] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'h0000_DEAD};
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < 3; i++) begin
      issue(addr[i], 32'h0, 1'b0, sz[i]);
      wait_resp(lat, rd, er);
      total++; if (rd !== exp[i] || er !== 1'b0 || lat != 2)
        begin bad++; $display("FAIL ld_size%0d got=%h err=%0b lat=%0d exp=%h err=0 lat=2", i, rd, er, lat, exp[i]); end
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er; int we0, io0;
    we0 = n_ram_we; io0 = n_io_valid;
    issue(32'h12, 32'h0, 1'b0, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (er !== 1'b1 || lat != 1 || rd !== 32'd0)
      begin bad++; $display("FAIL mis_ldw err=%0b lat=%0d rdata=%h exp err=1 lat=1 rdata=0", er, lat, rd); end
    issue(32'h81, 32'h1234_5678, 1'b1, SZ_H);
    wait_resp(lat, rd, er);
    total++; if (er !== 1'b1 || lat != 1)
      begin bad++; $display("FAIL mis_sth err=%0b lat=%0d exp err=1 lat=1", er, lat); end
    total++; if (n_ram_we != we0 || n_io_valid != io0)
      begin bad++; $display("FAIL mis_side ram_we=%0d io_valid=%0d exp 0/0", n_ram_we - we0, n_io_valid - io0); end
    issue(32'h80, 32'h0, 1'b0, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (er !== 1'b1 || lat != 1)
      begin bad++; $display("FAIL out_of_range err=%0b lat=%0d exp err=1 lat=1", er, lat); end
  endtask

  task automatic test_mmio();
    int io_hi = 0; int resp_k = -1; logic [31:0] rd = '0; logic er = 1'b1; logic fld_ok = 1'b1;
    io_rdata = 32'h1234_5678;
    issue(32'hF000_0004, 32'h0, 1'b0, SZ_W);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (io_valid) begin
        io_hi++;
        if (io_addr !== 32'hF000_0004 || io_we !== 1'b0 || io_size !== SZ_W) fld_ok = 1'b0;
      end
      if (resp_valid && resp_k < 0) begin resp_k = k; rd = resp_rdata; er = resp_err; end
      io_ack = (k == 4);
    end
    io_ack = 1'b0;
    total++; if (io_hi != 4) begin bad++; $display("FAIL io_valid_cycles got=%0d exp=4", io_hi); end
    total++; if (fld_ok !== 1'b1) begin bad++; $display("FAIL io_fields got=bad exp=F0000004/load/word"); end
    total++; if (resp_k != 5 || rd !== 32'h1234_5678 || er !== 1'b0)
      begin bad++; $display("FAIL io_resp lat=%0d rdata=%h err=%0b exp lat=5 rdata=12345678 err=0", resp_k, rd, er); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [31:0] rd; logic er; int io0, r0;
    io0 = n_io_valid;
    issue(32'hF000_0008, 32'hCAFE_0001, 1'b1, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (er !== 1'b1 || rd !== 32'd0 || lat != 10)
      begin bad++; $display("FAIL tmo_resp err=%0b rdata=%h lat=%0d exp err=1 rdata=0 lat=10", er, rd, lat); end
    total++; if (n_io_valid - io0 != 8) begin bad++; $display("FAIL tmo_io_cycles got=%0d exp=8", n_io_valid - io0); end
    r0 = n_resp;
    @(negedge clk); io_ack = 1'b1;
    @(negedge clk); io_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (n_resp != r0 || req_ready !== 1'b1)
      begin bad++; $display("FAIL stray_ack resp=%0d ready=%0b exp resp=0 ready=1", n_resp - r0, req_ready); end
  endtask
`endif

  task automatic test_reset_mid_io();
    int lat; logic [31:0] rd; logic er; int r0;
    issue(32'hF000_0010, 32'h0, 1'b0, SZ_W);
    @(negedge clk);
    total++; if (io_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_io got=%0b exp=1", io_valid); end
    r0 = n_resp;
    #2 rst = 1'b1;
    #1;
    total++; if (io_valid !== 1'b0 || req_ready !== 1'b0)
      begin bad++; $display("FAIL rst_async io_valid=%0b ready=%0b exp 0/0", io_valid, req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b exp=1", req_ready); end
    repeat (3) @(negedge clk);
    total++; if (n_resp != r0) begin bad++; $display("FAIL rst_no_resp got=%0d exp=0", n_resp - r0); end
    issue(32'h10, 32'h0, 1'b0, SZ_W);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2)
      begin bad++; $display("FAIL post_rst_load got=%h err=%0b lat=%0d exp=deadbeef err=0 lat=2", rd, er, lat); end
  endtask

  initial begin
    test_reset();
    test_ram_word();
    test_ram_sizes();
    test_misaligned();
    test_mmio();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_io();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
